// File: rtl/idct_butterfly.sv
// 8-point 1-D inverse DCT (Chen flow), four register stages, one vector per cycle.
// Valid/ready handshake with a global stall: the whole pipe advances or holds together.
module idct_butterfly #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [8*DATA_W-1:0]   DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [8*DATA_W-1:0]   OUT_DATA
);

  typedef logic signed [DATA_W-1:0] lane_t;

  // Product width covers a DATA_W operand times a 17-bit unsigned constant without overflow.
  localparam int unsigned PW = DATA_W + 18;

  localparam logic [16:0] K4 = 17'd46340;
  localparam logic [16:0] S8 = 17'd25079;
  localparam logic [16:0] C8 = 17'd60547;
  localparam logic [16:0] S1 = 17'd12785;
  localparam logic [16:0] C1 = 17'd64276;
  localparam logic [16:0] S5 = 17'd54491;
  localparam logic [16:0] C5 = 17'd36409;

  function automatic lane_t mulk(input lane_t a, input logic [16:0] k);
    logic signed [PW-1:0] aw;
    logic signed [PW-1:0] kw;
    logic signed [PW-1:0] p;
    aw = PW'(a);
    kw = $signed(PW'(k));
    p  = (aw * kw) >>> 16;
    return p[DATA_W-1:0];
  endfunction

  // Sum wraps at DATA_W before the floor halving.
  function automatic lane_t half(input lane_t s);
    return s >>> 1;
  endfunction

  lane_t x_in  [8];
  lane_t s1_d  [8];
  lane_t s1_q  [8];
  lane_t s2_d  [8];
  lane_t s2_q  [8];
  lane_t s3_d  [8];
  lane_t s3_q  [8];
  lane_t s4_d  [8];
  lane_t s4_q  [8];
  logic [3:0] v_d;
  logic [3:0] v_q;
  logic       adv;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      x_in[i] = DATA[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    adv  = !v_q[3] || OUT_READY;
    v_d  = v_q;
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    s4_d = s4_q;
    if (adv) begin
      v_d = {v_q[2:0], IN_VALID};

      s1_d[0] = x_in[0];
      s1_d[1] = x_in[4];
      s1_d[2] = x_in[2];
      s1_d[3] = x_in[6];
      s1_d[4] = mulk(x_in[1], S1) - mulk(x_in[7], C1);
      s1_d[5] = mulk(x_in[5], S5) - mulk(x_in[3], C5);
      s1_d[6] = mulk(x_in[5], C5) + mulk(x_in[3], S5);
      s1_d[7] = mulk(x_in[1], C1) + mulk(x_in[7], S1);

      s2_d[0] = mulk(s1_q[0], K4) + mulk(s1_q[1], K4);
      s2_d[1] = mulk(s1_q[0], K4) - mulk(s1_q[1], K4);
      s2_d[2] = mulk(s1_q[2], S8) - mulk(s1_q[3], C8);
      s2_d[3] = mulk(s1_q[2], C8) + mulk(s1_q[3], S8);
      s2_d[4] = s1_q[4] + s1_q[5];
      s2_d[5] = s1_q[4] - s1_q[5];
      s2_d[6] = s1_q[7] - s1_q[6];
      s2_d[7] = s1_q[6] + s1_q[7];

      s3_d[0] = s2_q[0] + s2_q[3];
      s3_d[3] = s2_q[0] - s2_q[3];
      s3_d[1] = s2_q[1] + s2_q[2];
      s3_d[2] = s2_q[1] - s2_q[2];
      s3_d[4] = s2_q[4];
      s3_d[7] = s2_q[7];
      s3_d[5] = mulk(s2_q[6], K4) - mulk(s2_q[5], K4);
      s3_d[6] = mulk(s2_q[6], K4) + mulk(s2_q[5], K4);

      s4_d[0] = half(s3_q[0] + s3_q[7]);
      s4_d[7] = half(s3_q[0] - s3_q[7]);
      s4_d[1] = half(s3_q[1] + s3_q[6]);
      s4_d[6] = half(s3_q[1] - s3_q[6]);
      s4_d[2] = half(s3_q[2] + s3_q[5]);
      s4_d[5] = half(s3_q[2] - s3_q[5]);
      s4_d[3] = half(s3_q[3] + s3_q[4]);
      s4_d[4] = half(s3_q[3] - s3_q[4]);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      v_q <= '0;
      for (int i = 0; i < 8; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
        s3_q[i] <= '0;
        s4_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < 8; i++) begin
        s1_q[i] <= s1_d[i];
        s2_q[i] <= s2_d[i];
        s3_q[i] <= s3_d[i];
        s4_q[i] <= s4_d[i];
      end
    end
  end

  always_comb begin
    IN_READY  = adv;
    OUT_VALID = v_q[3];
    OUT_DATA  = '0;
    for (int i = 0; i < 8; i++) begin
      OUT_DATA[i*DATA_W +: DATA_W] = s4_q[i];
    end
  end

endmodule
